// File: rtl/shift_serdes.sv
// shift_serdes: N-bit universal shift register with a full-duplex serialiser/deserialiser burst mode.
// Define SHIFT_SERDES_PARITY_EN to add a registered parity output.
module shift_serdes #(
    parameter int N = 8,
    parameter logic [N-1:0] RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pdatain,
    input  logic         sdatain,
    input  logic         load,
    input  logic         shift,
    input  logic         rotate,
    input  logic         dir,
    input  logic         start,
    output logic [N-1:0] pdataout,
    output logic         sdataout,
    output logic         busy,
`ifdef SHIFT_SERDES_PARITY_EN
    output logic         done,
    output logic         parity
`else
    output logic         done
`endif
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t       r_state, w_state;
    logic [N-1:0] r_reg, w_reg, w_shifted;
    logic [CW-1:0] r_cnt, w_cnt;
    logic         r_dir, w_dir, r_done, w_done;
    logic         w_sdir, w_out, w_in;
    always_comb begin
        w_state   = r_state;
        w_reg     = r_reg;
        w_cnt     = r_cnt;
        w_dir     = r_dir;
        w_done    = 1'b0;
        // a burst shifts in its latched direction; idle single steps follow the live dir input
        w_sdir    = (r_state == BURST) ? r_dir : dir;
        w_out     = w_sdir ? r_reg[0] : r_reg[N-1];
        w_in      = (r_state == IDLE && rotate) ? w_out : sdatain;
        w_shifted = w_sdir ? {w_in, r_reg[N-1:1]} : {r_reg[N-2:0], w_in};
        if (r_state == BURST) begin
            w_reg = w_shifted;
            w_cnt = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                w_state = IDLE;
                w_done  = 1'b1;
            end
        end else if (start) begin
            w_reg   = pdatain;
            w_dir   = dir;
            w_cnt   = CW'(N);
            w_state = BURST;
        end else if (load) begin
            w_reg = pdatain;
        end else if (shift) begin
            w_reg = w_shifted;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_reg   <= RESET_VALUE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_reg   <= w_reg;
            r_cnt   <= w_cnt;
            r_dir   <= w_dir;
            r_done  <= w_done;
        end
    end
`ifdef SHIFT_SERDES_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity <= 1'b0;
        else       parity <= ^w_reg;
    end
`endif
    assign pdataout = r_reg;
    assign sdataout = r_dir ? r_reg[0] : r_reg[N-1];
    assign busy     = (r_state == BURST);
    assign done     = r_done;
endmodule

// File: tb/tb_shift_serdes.sv
// tb_shift_serdes: scoreboard bench for shift_serdes (N=8) with an arithmetic reference model.
module tb_shift_serdes;
    localparam int N = 8;
    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] pdatain = '0;
    logic       sdatain = 1'b0, load = 1'b0, shift = 1'b0, rotate = 1'b0, dir = 1'b0, start = 1'b0;
    logic [7:0] pdataout;
    logic       sdataout, busy, done;
`ifdef SHIFT_SERDES_PARITY_EN
    logic       parity;
`endif

    always #5 clk = ~clk;

    shift_serdes #(.N(N)) dut (
        .clk(clk), .reset(reset), .pdatain(pdatain), .sdatain(sdatain),
        .load(load), .shift(shift), .rotate(rotate), .dir(dir), .start(start),
        .pdataout(pdataout), .sdataout(sdataout), .busy(busy),
`ifdef SHIFT_SERDES_PARITY_EN
        .done(done), .parity(parity)
`else
        .done(done)
`endif
    );

    typedef struct {
        int pd;
        bit busy;
        bit done;
        bit sd;
        bit par;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    int m_reg = 0, m_left = 0;
    bit m_busy = 0, m_dir = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit model_sd();
        return m_dir ? m_reg[0] : m_reg[7];
    endfunction

    function automatic bit model_par(input int v);
        bit p = 0;
        for (int i = 0; i < N; i++) p ^= v[i];
        return p;
    endfunction

    // shift as arithmetic: toward MSB is *2 mod 256, toward LSB is /2 plus the new top bit
    function automatic void model_shift(input bit d, input bit in_b);
        m_reg = d ? (m_reg / 2 + (in_b ? 128 : 0)) : ((m_reg * 2 + (in_b ? 1 : 0)) % 256);
    endfunction

    task automatic cycle(input bit st, input bit ld, input bit sh, input bit rot, input bit d,
                         input bit lb, input bit s, input int pd);
        exp_t e;
        bit sin_b, o;
        @(negedge clk);
        sin_b = lb ? model_sd() : s;
        start = st; load = ld; shift = sh; rotate = rot; dir = d; sdatain = sin_b; pdatain = 8'(pd);
        e.done = 0;
        if (m_busy) begin
            model_shift(m_dir, sin_b);
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                e.done = 1;
            end
        end else if (st) begin
            m_reg = pd; m_dir = d; m_left = N; m_busy = 1;
        end else if (ld) begin
            m_reg = pd;
        end else if (sh) begin
            o = d ? m_reg[0] : m_reg[7];
            model_shift(d, rot ? o : sin_b);
        end
        e.pd = m_reg; e.busy = m_busy; e.sd = model_sd(); e.par = model_par(m_reg);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_now(input string name, input int v);
        @(posedge clk);
        #2;
        chk(name, 32'(pdataout), 32'(v));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_pdataout", 32'(pdataout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        m_reg = 0; m_busy = 0; m_left = 0; m_dir = 0;
        start = 0; load = 0; shift = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("pdataout", 32'(pdataout), 32'(e.pd));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
                if (e.busy) chk("sdataout", 32'(sdataout), 32'(e.sd));
`ifdef SHIFT_SERDES_PARITY_EN
                chk("parity", 32'(parity), 32'(e.par));
`endif
            end
        end
    end

    initial begin : driver
        #2;
        chk("init_pdataout", 32'(pdataout), 0);
        chk("init_busy", 32'(busy), 0);
        chk("init_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 1, 0, 0, 0, 0, 0, 8'h3C);
        cycle(0, 0, 1, 0, 0, 0, 1, 0);
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 0, 8'hCC); expect_now("load_cc", 8'hCC);
        cycle(0, 0, 1, 0, 0, 0, 1, 0);     expect_now("shl_1", 8'h99);
        cycle(0, 0, 1, 0, 0, 0, 1, 0);     expect_now("shl_2", 8'h33);
        cycle(0, 0, 1, 0, 0, 0, 1, 0);     expect_now("shl_3", 8'h67);
        cycle(0, 1, 0, 0, 0, 0, 0, 8'hCC);
        cycle(0, 0, 1, 0, 1, 0, 0, 0);     expect_now("shr", 8'h66);
        cycle(0, 1, 0, 0, 0, 0, 0, 8'hCC);
        cycle(0, 0, 1, 1, 0, 0, 0, 0);     expect_now("rol", 8'h99);
        cycle(0, 0, 1, 1, 1, 0, 0, 0);     expect_now("ror", 8'hCC);
        // loopback burst: sdatain follows the outgoing bit
        cycle(1, 0, 0, 0, 0, 0, 0, 8'hA5);
        for (int i = 0; i < N - 1; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);     expect_now("loopback", 8'hA5);
        idle(2);
        // priority, ignored load during burst, back-to-back start in the done cycle
        cycle(1, 1, 1, 0, 0, 0, 0, 8'h3C);
        for (int i = 0; i < N; i++) cycle(0, 1, 1, 1, 1, 0, 1'($urandom_range(0, 1)), 8'hFF);
        cycle(1, 0, 0, 0, 1, 0, 0, 8'h5A);
        for (int i = 0; i < N; i++) cycle(0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
        idle(2);
        cycle(0, 1, 0, 0, 0, 0, 0, 8'h07); expect_now("load_07", 8'h07);
        // abandon a burst after three shifts
        cycle(1, 0, 0, 0, 0, 0, 0, 8'hE1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        idle(10);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)));
        idle(N + 2);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
